// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: FSM states, ALU opcode map,
// and the multi-cycle opcode classifier.
package alu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_SLT = 4'd11;
    localparam logic [3:0] OP_ROT = 4'd12;

    localparam logic [3:0] OP_LAST_LEGAL = OP_ROT;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to an external ALU and returns its result.
// Optional WAIT-state watchdog enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_op,
    input  logic        req_inv,
    input  logic        req_inc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_inv,
    output logic        alu_inc,
    output logic        alu_rst,
    input  logic        alu_done,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err
);

    state_t      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        alu_inv_q, alu_inv_d;
    logic        alu_inc_q, alu_inc_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;
    logic [31:0] rsp_lo_q, rsp_lo_d;
    logic        rsp_err_q, rsp_err_d;
    // Illegal requests still pass through ISSUE (without touching alu_*) so
    // the error response lands one cycle after acceptance.
    logic        illegal_q, illegal_d;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_inv_d = alu_inv_q;
        alu_inc_d = alu_inc_q;
        rsp_hi_d  = rsp_hi_q;
        rsp_lo_d  = rsp_lo_q;
        rsp_err_d = rsp_err_q;
        illegal_d = illegal_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
        cnt_d     = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ISSUE;
                    if (req_op > OP_LAST_LEGAL) begin
                        illegal_d = 1'b1;
                    end else begin
                        illegal_d = 1'b0;
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_op_d  = req_op;
                        alu_inv_d = req_inv;
                        alu_inc_d = req_inc;
                    end
                end
            end
            ST_ISSUE: begin
                if (illegal_q) begin
                    state_d   = ST_RESP;
                    rsp_hi_d  = '0;
                    rsp_lo_d  = '0;
                    rsp_err_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (alu_done) begin
                    state_d   = ST_RESP;
                    rsp_hi_d  = alu_hi;
                    rsp_lo_d  = alu_lo;
                    rsp_err_d = 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    rsp_hi_d  = '0;
                    rsp_lo_d  = '0;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q   <= ST_IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_inv_q <= 1'b0;
            alu_inc_q <= 1'b0;
            rsp_hi_q  <= '0;
            rsp_lo_q  <= '0;
            rsp_err_q <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_inv_q <= alu_inv_d;
            alu_inc_q <= alu_inc_d;
            rsp_hi_q  <= rsp_hi_d;
            rsp_lo_q  <= rsp_lo_d;
            rsp_err_q <= rsp_err_d;
            illegal_q <= illegal_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_rst   = ~rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_inv   = alu_inv_q;
    assign alu_inc   = alu_inc_q;
    assign rsp_hi    = rsp_hi_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, maximum WAIT-state cycles before abort (used only with ALU_ISSUE_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req_valid / req_ready  in/out  1/1  request handshake; transfer when both high at a rising edge.
REQ-005 req_a, req_b  in  32 each  operands; req_op  in  4  ALU opcode; req_inv, req_inc  in  1 each  result-invert and increment flags.
REQ-006 alu_a, alu_b  out  32 each; alu_op  out  4; alu_inv, alu_inc  out  1 each; drive the ALU's a, b, aluop, output_inverted, output_inc.
REQ-007 alu_rst  out  1  active-high ALU reset; alu_done  in  1; alu_hi, alu_lo  in  32 each  ALU results.
REQ-008 rsp_valid / rsp_ready  out/in  1/1  response handshake; rsp_hi, rsp_lo  out  32 each; rsp_err  out  1.

Function
REQ-009 States IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-010 IDLE: on a request transfer, register all req_* fields into the alu_* outputs and go to ISSUE; legal opcodes are 0-12.
REQ-011 alu_* outputs SHALL remain stable from acceptance until the RESP-to-IDLE transition, so that the ALU's start detection fires exactly once.
REQ-012 ISSUE lasts exactly one cycle (operand settle), then WAIT; alu_done is ignored during ISSUE.
REQ-013 WAIT: at the first edge with alu_done=1, capture alu_hi/alu_lo into rsp_hi/rsp_lo, set rsp_err=0, go to RESP.
REQ-014 Latency: request accepted at edge N -> rsp_valid high after edge N+2 for single-cycle ops (0,1,4-12); for ops 2 (mul) and 3 (div), after the edge where alu_done is first sampled high.
REQ-015 Illegal opcode (13-15): no ALU issue; alu_* outputs keep their previous values; go directly to RESP with rsp_hi=rsp_lo=0 and rsp_err=1 after edge N+1.
REQ-016 RESP: rsp_valid=1; rsp_* held stable until rsp_ready=1 at an edge, then IDLE; a new request is accepted no earlier than the following cycle.
REQ-017 rsp_valid, rsp_hi, rsp_lo, rsp_err SHALL change only on state transitions into or out of RESP.
REQ-018 req_valid while req_ready=0 SHALL have no effect; the requester holds the request.

Reset
REQ-019 rst=0 at an edge: state IDLE; rsp_valid=0, rsp_hi=rsp_lo=0, rsp_err=0, alu_a=alu_b=0, alu_op=0, alu_inv=alu_inc=0, timeout counter=0.
REQ-020 alu_rst SHALL equal the inverse of rst (combinational), so the ALU is held in reset whenever this block is.
REQ-021 Reset during ISSUE, WAIT or RESP aborts the operation with no response; a late alu_done after reset release in IDLE SHALL be ignored.

Configuration
REQ-022 With macro ALU_ISSUE_TIMEOUT_EN defined: a counter runs in WAIT; if TIMEOUT_CYCLES cycles elapse without alu_done, go to RESP with rsp_hi=rsp_lo=0 and rsp_err=1; alu_done and expiry on the same edge -> alu_done wins.
REQ-023 Without ALU_ISSUE_TIMEOUT_EN: no counter is present; WAIT lasts until alu_done or reset; rsp_err is set only for illegal opcodes.

Structure
REQ-024 A shared package SHALL hold the state enum, the opcode constants (OP_ADD=0 ... OP_ROT=12), OP_LAST_LEGAL=12, and an is_multicycle(op) function (true for 2 and 3).
REQ-025 This block is a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-026 Op 0, a=5, b=7, rsp_ready=1; ALU returns lo=12 -> rsp_lo=12, rsp_err=0, rsp_valid high after edge N+2.
REQ-027 Op 2, a=3, b=4; alu_done held low 33 cycles -> alu_* stable throughout, req_ready=0, rsp_lo=12 captured on the done edge.
REQ-028 Op 14 -> rsp_err=1, rsp_hi=rsp_lo=0 after edge N+1; alu_op unchanged.
REQ-029 Response with rsp_ready=0 for 5 cycles, new req_valid asserted meanwhile -> response held, request not accepted until the cycle after rsp handshake.
REQ-030 rst=0 in WAIT of op 3 -> next cycle rsp_valid=0, alu_rst=1, state IDLE; no response emitted.
REQ-031 (ALU_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=8) Op 3 with alu_done stuck low -> rsp_err=1 after 8 WAIT cycles; rerun with alu_done high on the 8th cycle -> rsp_err=0.
